// File: rtl/softmax_argmax.sv
// softmax_argmax: sequential argmax over a captured vector of IEEE-754 single-precision
// lanes. One lane is compared per clock. The block returns the winning index, the raw bits
// of the winning lane, and a flag that is set if any lane was NaN.
module softmax_argmax #(
  parameter int unsigned VLEN  = 4,
  parameter int unsigned IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VLEN*32-1:0]   in_vector,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_index,
  output logic [31:0]          out_value,
  output logic                 out_nan
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e              state_q, state_d;
  logic [VLEN*32-1:0]  vec_q, vec_d;
  logic [31:0]         best_q, best_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                nan_q, nan_d;
  logic [31:0]         lane_first;
  logic [31:0]         lane_cur;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'h0);
  endfunction

  // Strict "a beats b". NaN never wins but is displaced by anything, and the two zeros compare
  // equal.
  function automatic logic greater(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a))                               return 1'b0;
    else if (is_nan(b))                          return 1'b1;
    else if (a[30:0] == 31'h0 && b[30:0] == 31'h0) return 1'b0;
    else if (a[31] != b[31])                     return ~a[31];
    else if (!a[31])                             return a[30:0] > b[30:0];
    else                                         return a[30:0] < b[30:0];
  endfunction

  // Lane 0 is the most significant word of the packed vector.
  always_comb begin
    lane_first = in_vector[VLEN*32-1 -: 32];
    lane_cur   = vec_q[32*(int'(VLEN) - 1 - int'(cnt_q)) +: 32];
  end

  // Next-state: capture in IDLE, scan one lane per cycle, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    nan_d   = nan_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          vec_d   = in_vector;
          best_d  = lane_first;
          idx_d   = '0;
          cnt_d   = IDX_W'(1);
          nan_d   = is_nan(lane_first);
          state_d = (VLEN == 1) ? StDone : StScan;
        end
      end
      StScan: begin
        if (greater(lane_cur, best_q)) begin
          best_d = lane_cur;
          idx_d  = cnt_q;
        end
        nan_d = nan_q | is_nan(lane_cur);
        if (cnt_q == IDX_W'(VLEN - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset discards any partial or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nan_q   <= nan_d;
    end
  end

  // Handshake flags decode straight from the state; result outputs come from registers.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_index = idx_q;
    out_value = best_q;
    out_nan   = nan_q;
  end

endmodule

// File: tb/tb_softmax_argmax.sv
// Directed testbench for softmax_argmax with VLEN=4. Inputs are driven and outputs sampled
// 1ns after the rising edge.
module tb_softmax_argmax;

  localparam int unsigned VLEN  = 4;
  localparam int unsigned IDX_W = 2;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [VLEN*32-1:0] in_vector;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_index;
  logic [31:0]        out_value;
  logic               out_nan;

  int n_checks = 0;
  int n_fail   = 0;

  softmax_argmax #(.VLEN(VLEN), .IDX_W(IDX_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vector (in_vector),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value),
    .out_nan   (out_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector in IDLE and let the next edge take it; scramble the bus afterwards.
  task automatic accept(input logic [VLEN*32-1:0] vec);
    in_vector = vec;
    in_valid  = 1'b1;
    check("accept_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid  = 1'b0;
    in_vector = ~vec;
  endtask

  // Wait (bounded) for out_valid, then check latency and the result.
  task automatic await_result(input string tag, input logic [31:0] exp_idx,
                              input logic [31:0] exp_val, input logic exp_nan);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, VLEN - 1);
    check({tag, "_index"}, {30'h0, out_index}, exp_idx);
    check({tag, "_value"}, out_value, exp_val);
    check({tag, "_nan"}, {31'h0, out_nan}, {31'h0, exp_nan});
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rel_in_ready"}, {31'h0, in_ready}, 32'h1);
    check({tag, "_rel_out_valid"}, {31'h0, out_valid}, 32'h0);
  endtask

  localparam logic [127:0] VecSoftmax = {32'h3890969E, 32'h39D53C13, 32'h3D388CBF, 32'h3F745809};
  localparam logic [127:0] VecTie     = {4{32'h3E800000}};
  localparam logic [127:0] VecSigns   = {32'hBF800000, 32'h80000000, 32'h00000000, 32'hC0000000};
  localparam logic [127:0] VecNan     = {32'h7FC00000, 32'h3F000000, 32'h7F800001, 32'h3E000000};
  localparam logic [127:0] VecAllNan  = {4{32'h7FC00000}};
  localparam logic [127:0] VecPow     = {32'h40000000, 32'h40800000, 32'h41500000, 32'h41C80000};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vector = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_index", {30'h0, out_index}, 32'h0);
    check("reset_value", out_value, 32'h0);
    check("reset_nan", {31'h0, out_nan}, 32'h0);

    accept(VecSoftmax);
    await_result("softmax", 32'd3, 32'h3F745809, 1'b0);
    release_result("softmax");

    accept(VecTie);
    await_result("tie", 32'd0, 32'h3E800000, 1'b0);
    release_result("tie");

    accept(VecSigns);
    await_result("signs", 32'd1, 32'h80000000, 1'b0);
    release_result("signs");

    accept(VecNan);
    await_result("nan", 32'd1, 32'h3F000000, 1'b1);
    release_result("nan");

    accept(VecAllNan);
    await_result("allnan", 32'd0, 32'h7FC00000, 1'b1);
    release_result("allnan");

    // Backpressure: hold the result while a second vector waits on the input.
    accept(VecSoftmax);
    await_result("bp_first", 32'd3, 32'h3F745809, 1'b0);
    in_vector = VecSigns;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_index", {30'h0, out_index}, 32'd3);
      check("bp_value", out_value, 32'h3F745809);
      check("bp_nan", {31'h0, out_nan}, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_in_ready", {31'h0, in_ready}, 32'h1);
    check("bp_idle_out_valid", {31'h0, out_valid}, 32'h0);
    accept(VecSigns);
    await_result("bp_second", 32'd1, 32'h80000000, 1'b0);
    release_result("bp_second");

    // Reset one cycle into the scan discards the vector.
    accept(VecSoftmax);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_index", {30'h0, out_index}, 32'h0);
    check("rst_value", out_value, 32'h0);
    check("rst_nan", {31'h0, out_nan}, 32'h0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("rst_no_out_valid", seen, 32'd0);
      check("rst_still_idle", {31'h0, in_ready}, 32'h1);
    end
    accept(VecPow);
    await_result("after_rst", 32'd3, 32'h41C80000, 1'b0);
    release_result("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
